// File: rtl/sevseg_pkg.sv
// rtl/sevseg_pkg.sv - digit index type, slot FSM states and anode codes for the scan controller
package sevseg_pkg;

   typedef logic [1:0] digit_t;

   typedef enum logic {
      S_BLANK = 1'b0,
      S_ON    = 1'b1
   } state_t;

   localparam logic [3:0] AN_DIG0 = 4'b1110;
   localparam logic [3:0] AN_DIG1 = 4'b1101;
   localparam logic [3:0] AN_DIG2 = 4'b1011;
   localparam logic [3:0] AN_DIG3 = 4'b0111;
   localparam logic [3:0] AN_OFF  = 4'b1111;

   function automatic logic [3:0] an_code(input digit_t d);
      logic [3:0] code;
      unique case (d)
         2'd0:    code = AN_DIG0;
         2'd1:    code = AN_DIG1;
         2'd2:    code = AN_DIG2;
         default: code = AN_DIG3;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/sevseg_slot_timer.sv
// rtl/sevseg_slot_timer.sv - per-slot cycle counter flagging the blank-end and slot-end cycles
module sevseg_slot_timer
   import sevseg_pkg::*;
#(
   parameter int SCAN_DIV  = 100000,
   parameter int BLANK_CYC = 1000
) (
   input  logic CLK,
   input  logic RST_N,
   output logic blank_end,
   output logic slot_end
);

   localparam int CW = $clog2(SCAN_DIV);
   localparam logic [CW-1:0] SLOT_LAST  = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

   logic [CW-1:0] cnt;

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         cnt <= '0;
      end else if (slot_end) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign slot_end  = (cnt == SLOT_LAST);
   // With no blank phase there is no blank-end cycle to flag.
   assign blank_end = (BLANK_CYC > 0) && (cnt == BLANK_LAST);

endmodule

// File: rtl/sevseg_scan_ctrl.sv
// rtl/sevseg_scan_ctrl.sv - 4-digit multiplexed display scanner with PWM dimming and frame-atomic updates
// Optional leading-zero suppression is built when SEVSEG_LEADING_ZERO_BLANK_EN is defined.
module sevseg_scan_ctrl
   import sevseg_pkg::*;
#(
   parameter int SCAN_DIV  = 100000,
   parameter int BLANK_CYC = 1000
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        LOAD_VALID,
   output logic        LOAD_READY,
   input  logic [15:0] LOAD_DATA,
   input  logic [3:0]  BRIGHT,
   output logic [3:0]  AN,
   output logic [3:0]  BCD,
   output logic        BLANK,
   output logic        FRAME_DONE
);

   state_t      state, state_nxt;
   digit_t      digit;
   logic [3:0]  pwm_cnt;
   logic [15:0] active, shadow;
   logic        pending;
   logic        blank_end, slot_end;
   logic        on_phase, suppress, lit, frame_end;
   logic [3:0]  an_nxt, bcd_nxt;

   sevseg_slot_timer #(
      .SCAN_DIV  (SCAN_DIV),
      .BLANK_CYC (BLANK_CYC)
   ) u_timer (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .blank_end (blank_end),
      .slot_end  (slot_end)
   );

   always_ff @(posedge CLK) begin
      if (!RST_N) state <= S_BLANK;
      else        state <= state_nxt;
   end

   // Outputs are computed here from current state and registered below, so
   // every output lags the internal slot count by exactly one cycle.
   always_comb begin
      state_nxt = state;
      on_phase  = 1'b0;
      suppress  = 1'b0;
      case (state)
         S_BLANK: begin
            on_phase = (BLANK_CYC == 0);
            if ((BLANK_CYC == 0) || blank_end) state_nxt = S_ON;
         end
         S_ON: begin
            on_phase = 1'b1;
            if (slot_end && (BLANK_CYC != 0)) state_nxt = S_BLANK;
         end
         default: state_nxt = S_BLANK;
      endcase
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
      case (digit)
         2'd3:    suppress = (active[15:12] == 4'd0);
         2'd2:    suppress = (active[15:8] == 8'd0);
         2'd1:    suppress = (active[15:4] == 12'd0);
         default: suppress = 1'b0;
      endcase
`endif
      lit       = on_phase && (pwm_cnt <= BRIGHT) && !suppress;
      an_nxt    = lit ? an_code(digit) : AN_OFF;
      bcd_nxt   = active[{digit, 2'b00} +: 4];
      frame_end = slot_end && (digit == 2'd3);
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         digit      <= '0;
         pwm_cnt    <= '0;
         active     <= '0;
         shadow     <= '0;
         pending    <= 1'b0;
         AN         <= AN_OFF;
         BLANK      <= 1'b1;
         BCD        <= '0;
         FRAME_DONE <= 1'b0;
      end else begin
         if (slot_end) digit <= digit + 2'd1;
         pwm_cnt <= (on_phase && !slot_end) ? pwm_cnt + 4'd1 : 4'd0;
         // Transfer needs pending=0 and commit needs pending=1, so they never collide;
         // a word arriving on the frame-end cycle waits for the next frame end.
         if (LOAD_VALID && !pending) begin
            shadow  <= LOAD_DATA;
            pending <= 1'b1;
         end else if (frame_end && pending) begin
            active  <= shadow;
            pending <= 1'b0;
         end
         AN         <= an_nxt;
         BLANK      <= !lit;
         BCD        <= bcd_nxt;
         FRAME_DONE <= frame_end;
      end
   end

   assign LOAD_READY = !pending;

endmodule

// File: tb/tb_sevseg_scan_ctrl.sv
// tb/tb_sevseg_scan_ctrl.sv - directed scoreboard bench for sevseg_scan_ctrl (honours SEVSEG_LEADING_ZERO_BLANK_EN)
module tb_sevseg_scan_ctrl;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic        LOAD_VALID;
   logic        LOAD_READY;
   logic [15:0] LOAD_DATA;
   logic [3:0]  BRIGHT;
   logic [3:0]  AN;
   logic [3:0]  BCD;
   logic        BLANK;
   logic        FRAME_DONE;

   logic        rst_n_p;
   logic        valid_p = 1'b0;
   logic        ready_p;
   logic [15:0] data_p = 16'h0000;
   logic [3:0]  bright_p = 4'h0;
   logic [3:0]  an_p;
   logic [3:0]  bcd_p;
   logic        blank_p;
   logic        fd_p;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] exp_q[$];
   logic        lit_p;

`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
   localparam bit LZ = 1'b1;
`else
   localparam bit LZ = 1'b0;
`endif

   sevseg_scan_ctrl #(.SCAN_DIV(8), .BLANK_CYC(2)) dut (
      .CLK(CLK), .RST_N(RST_N), .LOAD_VALID(LOAD_VALID), .LOAD_READY(LOAD_READY),
      .LOAD_DATA(LOAD_DATA), .BRIGHT(BRIGHT), .AN(AN), .BCD(BCD), .BLANK(BLANK),
      .FRAME_DONE(FRAME_DONE)
   );

   sevseg_scan_ctrl #(.SCAN_DIV(40), .BLANK_CYC(0)) dut_pwm (
      .CLK(CLK), .RST_N(rst_n_p), .LOAD_VALID(valid_p), .LOAD_READY(ready_p),
      .LOAD_DATA(data_p), .BRIGHT(bright_p), .AN(an_p), .BCD(bcd_p), .BLANK(blank_p),
      .FRAME_DONE(fd_p)
   );

   initial forever #5 CLK = ~CLK;

   task automatic tick();
      @(negedge CLK);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] an_exp(input int d);
      logic [3:0] one;
      one = 4'b0001;
      return ~(one << d);
   endfunction

   function automatic logic lz_off(input logic [15:0] w, input int d);
      if (LZ && d == 3) return w[15:12] == 4'd0;
      if (LZ && d == 2) return w[15:8] == 8'd0;
      if (LZ && d == 1) return w[15:4] == 12'd0;
      return 1'b0;
   endfunction

   // Starts on the cycle before a digit-0 slot and ends on that frame's FRAME_DONE cycle.
   task automatic check_frame(input string name);
      logic [15:0] w;
      logic        lit;
      w = exp_q.pop_front();
      for (int d = 0; d < 4; d++) begin
         for (int c = 0; c < 8; c++) begin
            tick();
            lit = (c >= 2) && !lz_off(w, d);
            chk($sformatf("%s d%0d c%0d an", name, d, c), 32'(AN), 32'(lit ? an_exp(d) : 4'hF));
            chk($sformatf("%s d%0d c%0d blank", name, d, c), 32'(BLANK), 32'(!lit));
            chk($sformatf("%s d%0d c%0d bcd", name, d, c), 32'(BCD), 32'(w[4*d +: 4]));
            chk($sformatf("%s d%0d c%0d frame_done", name, d, c), 32'(FRAME_DONE),
                32'((d == 3) && (c == 7)));
         end
      end
   endtask

   task automatic reset_checks(input string name);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("%s %0d an", name, i), 32'(AN), 32'hF);
         chk($sformatf("%s %0d blank", name, i), 32'(BLANK), 32'h1);
         chk($sformatf("%s %0d bcd", name, i), 32'(BCD), 32'h0);
         chk($sformatf("%s %0d frame_done", name, i), 32'(FRAME_DONE), 32'h0);
         chk($sformatf("%s %0d ready", name, i), 32'(LOAD_READY), 32'h1);
      end
   endtask

   initial begin
      RST_N = 1'b0; rst_n_p = 1'b0;
      LOAD_VALID = 1'b0; LOAD_DATA = 16'h0000; BRIGHT = 4'hF;
      reset_checks("reset");

      // Release with a load offered on the first cycle: the boot frame stays blank data.
      RST_N = 1'b1;
      exp_q.push_back(16'h0000); exp_q.push_back(16'h4321);
      LOAD_VALID = 1'b1; LOAD_DATA = 16'h4321;
      fork
         check_frame("boot");
         begin tick(); LOAD_VALID = 1'b0; chk("ready after load", 32'(LOAD_READY), 32'h0); end
      join
      check_frame("h4321");

      // Back-pressure: second word stalls until the first commits.
      exp_q.push_back(16'h4321); exp_q.push_back(16'h1111); exp_q.push_back(16'h2222);
      LOAD_VALID = 1'b1; LOAD_DATA = 16'h1111;
      fork
         check_frame("h4321 again");
         begin
            tick(); chk("ready after first", 32'(LOAD_READY), 32'h0);
            LOAD_DATA = 16'h2222;
            repeat (30) tick();
            chk("ready while stalled", 32'(LOAD_READY), 32'h0);
            tick(); chk("ready at frame end", 32'(LOAD_READY), 32'h1);
         end
      join
      fork
         check_frame("h1111");
         begin tick(); LOAD_VALID = 1'b0; chk("ready after second", 32'(LOAD_READY), 32'h0); end
      join
      check_frame("h2222");
      chk("ready after commit", 32'(LOAD_READY), 32'h1);

      // Transfer landing on the frame-end edge commits one frame later.
      exp_q.push_back(16'h2222); exp_q.push_back(16'h2222); exp_q.push_back(16'h5555);
      fork
         check_frame("h2222 hold");
         begin
            repeat (31) tick();
            LOAD_VALID = 1'b1; LOAD_DATA = 16'h5555;
            tick(); LOAD_VALID = 1'b0;
            chk("ready after coincident load", 32'(LOAD_READY), 32'h0);
         end
      join
      check_frame("h2222 last");
      check_frame("h5555");

      exp_q.push_back(16'h5555); exp_q.push_back(16'h0070);
      LOAD_VALID = 1'b1; LOAD_DATA = 16'h0070;
      fork
         check_frame("h5555 again");
         begin tick(); LOAD_VALID = 1'b0; end
      join
      check_frame("h0070");

      // Reset during the digit-2 slot with a word pending: it must never appear.
      LOAD_VALID = 1'b1; LOAD_DATA = 16'h9999;
      tick(); LOAD_VALID = 1'b0;
      chk("pending before reset", 32'(LOAD_READY), 32'h0);
      repeat (19) tick();
      RST_N = 1'b0;
      reset_checks("mid reset");
      RST_N = 1'b1;
      exp_q.push_back(16'h0000); exp_q.push_back(16'h0000);
      check_frame("after reset 0");
      check_frame("after reset 1");
      chk("ready after reset frames", 32'(LOAD_READY), 32'h1);

      // PWM instance: BRIGHT=0, 40-cycle slots, no blank phase.
      rst_n_p = 1'b1;
      for (int d = 0; d < 4; d++) begin
         for (int c = 0; c < 40; c++) begin
            tick();
            lit_p = ((c % 16) == 0) && !lz_off(16'h0000, d);
            chk($sformatf("pwm d%0d c%0d an", d, c), 32'(an_p), 32'(lit_p ? an_exp(d) : 4'hF));
            chk($sformatf("pwm d%0d c%0d blank", d, c), 32'(blank_p), 32'(!lit_p));
            chk($sformatf("pwm d%0d c%0d bcd", d, c), 32'(bcd_p), 32'h0);
            chk($sformatf("pwm d%0d c%0d frame_done", d, c), 32'(fd_p),
                32'((d == 3) && (c == 39)));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sevseg_scan_ctrl.md
SEVSEG_SCAN_CTRL -- requirements
Module: sevseg_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, meaning CLK cycles per digit slot (legal range 2..2^20).
REQ-002 SHALL have parameter BLANK_CYC, default 1000, meaning anti-ghost blank cycles at the start of each slot (legal range 0..SCAN_DIV-1).
REQ-003 SHALL have port CLK, input, 1, system clock; all logic on its rising edge.
REQ-004 SHALL have port RST_N, input, 1, reset, synchronous and active-low.
REQ-005 SHALL have port LOAD_VALID, input, 1, requester offers a new 4-digit word.
REQ-006 SHALL have port LOAD_READY, output, 1, controller can accept a word.
REQ-007 SHALL have port LOAD_DATA, input, 16, digits as [15:12]=digit3 .. [3:0]=digit0.
REQ-008 SHALL have port BRIGHT, input, 4, brightness level 0..15.
REQ-009 SHALL have port AN, output, 4, active-low one-hot anode enables.
REQ-010 SHALL have port BCD, output, 4, code of the digit in the current slot, driven to the downstream decoder.
REQ-011 SHALL have port BLANK, output, 1, high when segments must be off.
REQ-012 SHALL have port FRAME_DONE, output, 1, one-cycle pulse at the end of each 4-digit frame.

Function
REQ-013 SHALL scan the digits in the order 0,1,2,3,0...; each slot lasts exactly SCAN_DIV cycles.
REQ-014 SHALL use a two-state FSM per slot:
  - S_BLANK: BLANK_CYC cycles with AN=1111 and BLANK=1; skipped when BLANK_CYC=0.
  - S_ON: the remaining SCAN_DIV-BLANK_CYC cycles; then advance the digit and return to S_BLANK.
REQ-015 SHALL, in S_ON, run a 4-bit PWM counter that clears on S_ON entry and wraps 15->0.
REQ-016 SHALL, in S_ON, drive AN to the slot's one-hot-low code when pwm_cnt<=BRIGHT, otherwise AN=1111 and BLANK=1 (BRIGHT=15 full on, BRIGHT=0 on 1/16).
REQ-017 SHALL drive BCD with the slot digit from the active register in every cycle of the slot; values A-F pass through unchanged.
REQ-018 SHALL hold a shadow register and a pending flag, with LOAD_READY = !pending.
REQ-019 SHALL treat LOAD_VALID&&LOAD_READY as a transfer: shadow<=LOAD_DATA and pending<=1.
REQ-020 SHALL, in the last cycle of the digit-3 slot, assert FRAME_DONE and, if pending=1 in that cycle, copy shadow to active and clear pending.
REQ-021 SHALL make committed data visible on BCD from the first cycle of the next digit-0 slot; no frame may ever show mixed old and new digits.
REQ-022 SHALL, when a transfer and the frame end coincide (pending was 0), latch the word into shadow only and commit it at the following frame end.
REQ-023 SHALL keep LOAD_VALID with LOAD_READY=0 stalled, with no data lost and no overwrite of the shadow register.
REQ-024 SHALL register all outputs and SHALL NOT create any combinational path from an input to an output.

Reset
REQ-025 SHALL, on RST_N=0 at a clock edge, set: AN=1111, BLANK=1, BCD=0000, FRAME_DONE=0, LOAD_READY=1, active=0000_0000_0000_0000, pending=0, digit=0, state=S_BLANK, all counters=0.
REQ-026 SHALL discard a pending word on reset mid-frame and restart scanning at digit 0 after release.

Configuration
REQ-027 SHALL gate leading-zero blanking with macro SEVSEG_LEADING_ZERO_BLANK_EN.
  - Defined: digit3, digit2 and digit1 force BLANK=1 and AN=1111 for their whole slot when that digit and all higher digits are 0; digit0 is never suppressed.
  - Undefined: no suppression logic is built and all digits display.

Structure
REQ-028 SHALL place in package sevseg_pkg: the digit-index type (2 bits), the FSM state enum, constants AN_DIG0..AN_DIG3 (1110,1101,1011,0111) and AN_OFF (1111).
REQ-029 SHALL implement slot timing in one sub-module, sevseg_slot_timer, which counts SCAN_DIV and flags the blank-end and slot-end cycles.

Verification (SCAN_DIV=8, BLANK_CYC=2)
REQ-030 SHALL cover reset: hold RST_N=0 for 3 cycles, then release -> AN=1111, BLANK=1, LOAD_READY=1 during reset; first AN=1110 at cycle 3 after release.
REQ-031 SHALL cover a load: LOAD_DATA=16'h4321, BRIGHT=15 -> after the next FRAME_DONE, slots show BCD 1,2,3,4 with AN 1110,1101,1011,0111 for 6 cycles each.
REQ-032 SHALL cover back-pressure: two back-to-back words 16'h1111 then 16'h2222 -> LOAD_READY=0 after the first; the second is accepted after FRAME_DONE; display shows 1111 for exactly one frame, then 2222.
REQ-033 SHALL cover PWM: BRIGHT=0, SCAN_DIV=40, BLANK_CYC=0 -> in each slot, AN is active-low only on cycles 0, 16 and 32.
REQ-034 SHALL cover leading-zero blanking with SEVSEG_LEADING_ZERO_BLANK_EN defined: 16'h0070 -> digit3 and digit2 slots have AN=1111, digit1 shows 7, digit0 shows 0.
REQ-035 SHALL cover reset mid-frame: assert RST_N=0 during a digit-2 slot with pending=1 -> after release, active=0 and the old shadow word is never displayed.
